// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, flush and memory-wait sequencing for a 5-stage pipeline
module pipeline_ctrl #(
    parameter int INIT_CYCLES = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter bit FORWARD_EN  = 1'b1,
    parameter bit ZERO_REG    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  id_rs_i,
    input  logic [5:0]  id_rt_i,
    input  logic        id_uses_rs_i,
    input  logic        id_uses_rt_i,
    input  logic [5:0]  ex_rd_i,
    input  logic        ex_RegWrite_i,
    input  logic        ex_MemRead_i,
    input  logic [5:0]  mem_rd_i,
    input  logic        mem_RegWrite_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    input  logic        branch_taken_i,
    output logic        pc_en_o,
    output logic        pc_sel_target_o,
    output logic        ifid_en_o,
    output logic        idex_en_o,
    output logic        exmem_en_o,
    output logic        memwb_en_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic        exmem_flush_o,
    output logic        memwb_flush_o,
    output logic        busy_o,
    output logic [15:0] stall_cycles_o,
    output logic        mem_err_o
);
    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_e;

    state_e      state_q, state_d;
    logic [3:0]  init_cnt_q, init_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_q, stall_d;
    logic        mem_err_q, mem_err_d;
    logic        ex_hit, mem_hit, hazard, wait_now;

    assign ex_hit  = ((id_uses_rs_i && id_rs_i == ex_rd_i) || (id_uses_rt_i && id_rt_i == ex_rd_i))
                     && !(ZERO_REG && ex_rd_i == 6'd0);
    assign mem_hit = ((id_uses_rs_i && id_rs_i == mem_rd_i) || (id_uses_rt_i && id_rt_i == mem_rd_i))
                     && !(ZERO_REG && mem_rd_i == 6'd0);
    assign hazard  = (ex_MemRead_i && ex_RegWrite_i && ex_hit)
                     || (!FORWARD_EN && ((ex_RegWrite_i && ex_hit) || (mem_RegWrite_i && mem_hit)));
    // Once in MEM_WAIT the access is already outstanding, so only mem_ready matters
    assign wait_now = (state_q == MEM_WAIT) ? !mem_ready_i : (mem_req_i && !mem_ready_i);

    assign stall_cycles_o = stall_q;
    assign mem_err_o      = mem_err_q;

    // Per-cycle strobes by priority (wait > branch > hazard > advance) and next-state
    always_comb begin
        pc_en_o         = 1'b1;
        pc_sel_target_o = 1'b0;
        ifid_en_o       = 1'b1;
        idex_en_o       = 1'b1;
        exmem_en_o      = 1'b1;
        memwb_en_o      = 1'b1;
        ifid_flush_o    = 1'b0;
        idex_flush_o    = 1'b0;
        exmem_flush_o   = 1'b0;
        memwb_flush_o   = 1'b0;
        busy_o          = state_q != RUN;
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        wait_cnt_d      = wait_cnt_q;
        stall_d         = stall_q;
        mem_err_d       = mem_err_q;
        if (state_q == INIT) begin
            pc_en_o       = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            memwb_flush_o = 1'b1;
            init_cnt_d    = init_cnt_q - 4'd1;
            state_d       = (init_cnt_q == 4'd0) ? RUN : INIT;
        end else begin
            if (wait_now) begin
                pc_en_o       = 1'b0;
                ifid_en_o     = 1'b0;
                idex_en_o     = 1'b0;
                exmem_en_o    = 1'b0;
                memwb_flush_o = 1'b1;
                state_d       = MEM_WAIT;
                wait_cnt_d    = (state_q != MEM_WAIT) ? 16'd1
                              : (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
                mem_err_d     = mem_err_q || (wait_cnt_d >= 16'(MEM_TIMEOUT));
            end else begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
                if (branch_taken_i) begin
                    pc_sel_target_o = 1'b1;
                    ifid_flush_o    = 1'b1;
                    idex_flush_o    = 1'b1;
                    exmem_flush_o   = 1'b1;
                end else if (hazard) begin
                    pc_en_o      = 1'b0;
                    ifid_en_o    = 1'b0;
                    idex_flush_o = 1'b1;
                end
            end
            stall_d = (!pc_en_o && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        end
    end

    // State and debug registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= 4'(INIT_CYCLES - 1);
            wait_cnt_q <= 16'd0;
            stall_q    <= 16'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            mem_err_q  <= mem_err_d;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized run against a behavioural model, two parameter sets
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] id_rs, id_rt, ex_rd, mem_rd;
    logic id_uses_rs, id_uses_rt, ex_RegWrite, ex_MemRead, mem_RegWrite, mem_req, mem_ready, branch_taken;
    logic [1:0] pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en;
    logic [1:0] ifid_fl, idex_fl, exmem_fl, memwb_fl, busy, mem_err;
    logic [1:0][15:0] sc;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.INIT_CYCLES(5), .MEM_TIMEOUT(4), .FORWARD_EN(1'b1), .ZERO_REG(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs),
        .id_uses_rt_i(id_uses_rt), .ex_rd_i(ex_rd), .ex_RegWrite_i(ex_RegWrite), .ex_MemRead_i(ex_MemRead),
        .mem_rd_i(mem_rd), .mem_RegWrite_i(mem_RegWrite), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .branch_taken_i(branch_taken), .pc_en_o(pc_en[0]), .pc_sel_target_o(pc_sel[0]),
        .ifid_en_o(ifid_en[0]), .idex_en_o(idex_en[0]), .exmem_en_o(exmem_en[0]), .memwb_en_o(memwb_en[0]),
        .ifid_flush_o(ifid_fl[0]), .idex_flush_o(idex_fl[0]), .exmem_flush_o(exmem_fl[0]),
        .memwb_flush_o(memwb_fl[0]), .busy_o(busy[0]), .stall_cycles_o(sc[0]), .mem_err_o(mem_err[0])
    );

    pipeline_ctrl #(.INIT_CYCLES(3), .MEM_TIMEOUT(6), .FORWARD_EN(1'b0), .ZERO_REG(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs),
        .id_uses_rt_i(id_uses_rt), .ex_rd_i(ex_rd), .ex_RegWrite_i(ex_RegWrite), .ex_MemRead_i(ex_MemRead),
        .mem_rd_i(mem_rd), .mem_RegWrite_i(mem_RegWrite), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .branch_taken_i(branch_taken), .pc_en_o(pc_en[1]), .pc_sel_target_o(pc_sel[1]),
        .ifid_en_o(ifid_en[1]), .idex_en_o(idex_en[1]), .exmem_en_o(exmem_en[1]), .memwb_en_o(memwb_en[1]),
        .ifid_flush_o(ifid_fl[1]), .idex_flush_o(idex_fl[1]), .exmem_flush_o(exmem_fl[1]),
        .memwb_flush_o(memwb_fl[1]), .busy_o(busy[1]), .stall_cycles_o(sc[1]), .mem_err_o(mem_err[1])
    );

    localparam int M_INIT[2] = '{5, 3};
    localparam int M_TO[2]   = '{4, 6};
    localparam int M_FW[2]   = '{1, 0};
    localparam int M_ZR[2]   = '{1, 0};

    int init_left[2];
    bit in_wait[2];
    int wcnt[2];
    int stalls[2];
    bit err[2];

    function automatic bit m_hit(int k, logic [5:0] r);
        return ((id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r)) && !(M_ZR[k] == 1 && r == 6'd0);
    endfunction

    function automatic bit m_hazard(int k);
        if (ex_MemRead && ex_RegWrite && m_hit(k, ex_rd)) return 1'b1;
        if (M_FW[k] == 0 && ((ex_RegWrite && m_hit(k, ex_rd)) || (mem_RegWrite && m_hit(k, mem_rd)))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_waiting(int k);
        return in_wait[k] ? !mem_ready : (mem_req && !mem_ready);
    endfunction

    // {pc_en, pc_sel, busy, ifid, idex, exmem, memwb}; buffer action 2=zero, 1=load, 0=hold
    function automatic logic [10:0] m_out(int k);
        if (init_left[k] > 0) return {3'b001, 8'b10101010};
        if (m_waiting(k)) return {2'b00, in_wait[k], 8'b00000010};
        if (branch_taken) return {2'b11, in_wait[k], 8'b10101001};
        if (m_hazard(k)) return {2'b00, in_wait[k], 8'b00100101};
        return {2'b10, in_wait[k], 8'b01010101};
    endfunction

    function automatic logic [1:0] act(logic f, logic e);
        return f ? 2'd2 : (e ? 2'd1 : 2'd0);
    endfunction

    function automatic logic [10:0] d_out(int k);
        return {pc_en[k], pc_sel[k], busy[k], act(ifid_fl[k], ifid_en[k]), act(idex_fl[k], idex_en[k]),
                act(exmem_fl[k], exmem_en[k]), act(memwb_fl[k], memwb_en[k])};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [10:0] o;
            bit w;
            int nw;
            o = m_out(k);
            w = m_waiting(k);
            nw = in_wait[k] ? (wcnt[k] < 65535 ? wcnt[k] + 1 : wcnt[k]) : 1;
            if (!rst_n) begin
                init_left[k] <= M_INIT[k];
                in_wait[k] <= 1'b0;
                wcnt[k] <= 0;
                stalls[k] <= 0;
                err[k] <= 1'b0;
            end else if (init_left[k] > 0) begin
                init_left[k] <= init_left[k] - 1;
            end else begin
                if (!o[10] && stalls[k] < 65535) stalls[k] <= stalls[k] + 1;
                in_wait[k] <= w;
                wcnt[k] <= w ? nw : 0;
                if (w && nw >= M_TO[k]) err[k] <= 1'b1;
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_rs, id_rt, ex_rd, mem_rd} = '0;
        {id_uses_rs, id_uses_rt, ex_RegWrite, ex_MemRead, mem_RegWrite, mem_req, mem_ready, branch_taken} = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
        repeat (5) adv();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        adv();
        adv();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({pc_en[0], ifid_fl[0], idex_fl[0], exmem_fl[0], memwb_fl[0], busy[0]} !== 6'b011111) begin
                bad++;
                $display("FAIL reset_init cyc%0d got %b want 011111", i,
                         {pc_en[0], ifid_fl[0], idex_fl[0], exmem_fl[0], memwb_fl[0], busy[0]});
            end
            total++;
            if (pc_en[1] !== (i >= 3)) begin
                bad++;
                $display("FAIL reset_init3_pc_en cyc%0d got %b want %b", i, pc_en[1], i >= 3);
            end
            adv();
        end
        #1;
        total++;
        if ({pc_en[0], busy[0], sc[0]} !== {2'b10, 16'd0}) begin
            bad++;
            $display("FAIL reset_run got pc_en=%b busy=%b stalls=%0d want 1 0 0", pc_en[0], busy[0], sc[0]);
        end
    endtask

    task automatic test_load_use();
        adv();
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 6'd7; id_rs = 6'd7; id_uses_rs = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({pc_en[k], ifid_en[k], idex_fl[k], exmem_en[k], memwb_en[k], memwb_fl[k], exmem_fl[k], ifid_fl[k]}
                !== 8'b00111000) begin
                bad++;
                $display("FAIL load_use_stall dut%0d got %b want 00111000", k,
                         {pc_en[k], ifid_en[k], idex_fl[k], exmem_en[k], memwb_en[k], memwb_fl[k], exmem_fl[k], ifid_fl[k]});
            end
        end
        adv();
        idle();
        #1;
        total++;
        if ({pc_en, ifid_en, sc[0], sc[1]} !== {4'b1111, 16'd1, 16'd1}) begin
            bad++;
            $display("FAIL load_use_resume got pc_en=%b ifid_en=%b stalls=%0d/%0d want 11 11 1/1",
                     pc_en, ifid_en, sc[0], sc[1]);
        end
        adv();
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 6'd0; id_rs = 6'd0; id_uses_rs = 1'b1;
        #1;
        total++;
        if (pc_en !== 2'b01) begin
            bad++;
            $display("FAIL load_use_reg0 got pc_en=%b want 01 (zero reg ignored only in dut0)", pc_en);
        end
        adv();
        idle();
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({pc_en[k], pc_sel[k], ifid_fl[k], idex_fl[k], exmem_fl[k], memwb_fl[k], memwb_en[k]} !== 7'b1111101) begin
                bad++;
                $display("FAIL branch_flush dut%0d got %b want 1111101", k,
                         {pc_en[k], pc_sel[k], ifid_fl[k], idex_fl[k], exmem_fl[k], memwb_fl[k], memwb_en[k]});
            end
        end
        adv();
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 6'd9; id_rt = 6'd9; id_uses_rt = 1'b1;
        #1;
        total++;
        if ({pc_en, pc_sel, ifid_fl} !== 6'b111111) begin
            bad++;
            $display("FAIL branch_over_load_use got pc_en=%b sel=%b ifid_fl=%b want 11 11 11", pc_en, pc_sel, ifid_fl);
        end
        adv();
        idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({pc_en[0], ifid_en[0], idex_en[0], exmem_en[0], memwb_en[0], memwb_fl[0], busy[0]} !== {6'b000011, i != 0}) begin
                bad++;
                $display("FAIL mem_wait_frozen cyc%0d got %b want %b", i,
                         {pc_en[0], ifid_en[0], idex_en[0], exmem_en[0], memwb_en[0], memwb_fl[0], busy[0]}, {6'b000011, i != 0});
            end
            adv();
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if ({pc_en[0], memwb_fl[0], busy[0], ifid_en[0]} !== 4'b1011) begin
            bad++;
            $display("FAIL mem_wait_release got %b want 1011", {pc_en[0], memwb_fl[0], busy[0], ifid_en[0]});
        end
        adv();
        idle();
        #1;
        total++;
        if ({busy, mem_err, sc[0], sc[1]} !== {4'b0000, 16'd3, 16'd3}) begin
            bad++;
            $display("FAIL mem_wait_after got busy=%b err=%b stalls=%0d/%0d want 00 00 3/3", busy, mem_err, sc[0], sc[1]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (mem_err !== {i >= 6, i >= 4}) begin
                bad++;
                $display("FAIL timeout_rise cyc%0d got %b want %b", i, mem_err, {i >= 6, i >= 4});
            end
            adv();
        end
        mem_ready = 1'b1;
        adv();
        idle();
        #1;
        total++;
        if ({mem_err, busy} !== 4'b1100) begin
            bad++;
            $display("FAIL timeout_sticky got err=%b busy=%b want 11 00", mem_err, busy);
        end
        rst_n = 1'b0;
        adv();
        #1;
        total++;
        if (mem_err !== 2'b00) begin
            bad++;
            $display("FAIL timeout_clear got %b want 00", mem_err);
        end
        rst_n = 1'b1;
        repeat (5) adv();
    endtask

    task automatic test_forward();
        mem_RegWrite = 1'b1; mem_rd = 6'd12; id_rt = 6'd12; id_uses_rt = 1'b1;
        #1;
        total++;
        if ({pc_en[0], pc_en[1], ifid_en[1], idex_fl[1]} !== 4'b1001) begin
            bad++;
            $display("FAIL forward_raw got %b want 1001", {pc_en[0], pc_en[1], ifid_en[1], idex_fl[1]});
        end
        adv();
        idle();
        #1;
        total++;
        if (pc_en !== 2'b11) begin
            bad++;
            $display("FAIL forward_resume got %b want 11", pc_en);
        end
        adv();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = $urandom_range(0, 299) != 0;
            id_rs = 6'($urandom_range(0, 3));
            id_rt = 6'($urandom_range(0, 3));
            ex_rd = 6'($urandom_range(0, 3));
            mem_rd = 6'($urandom_range(0, 3));
            {id_uses_rs, id_uses_rt, ex_RegWrite, ex_MemRead, mem_RegWrite} = 5'($urandom);
            mem_req = $urandom_range(0, 2) == 0;
            mem_ready = $urandom_range(0, 1) == 1;
            branch_taken = $urandom_range(0, 7) == 0;
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({d_out(k), sc[k], mem_err[k]} !== {m_out(k), 16'(stalls[k]), err[k]}) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d got out=%b stalls=%0d err=%b want out=%b stalls=%0d err=%b",
                             k, c, d_out(k), sc[k], mem_err[k], m_out(k), stalls[k], err[k]);
                end
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_forward();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
